// File: rtl/vi_fault_recovery_seq.sv
// vi_fault_recovery_seq: host-side start/clear sequencer for the V-I supervisor.
// Optional fault capture (last_fault_v/i, fault_count) enabled by VI_SEQ_LOG_EN.
module vi_fault_recovery_seq #(
  parameter int unsigned            W            = 16,
  parameter logic signed [W-1:0]    V_SAFE       = 16'sh4000,
  parameter logic signed [W-1:0]    I_SAFE       = 16'sh4000,
  parameter int unsigned            COOLDOWN_CYC = 1000,
  parameter int unsigned            TIMEOUT_CYC  = 64,
  parameter int unsigned            STABLE_CYC   = 4096,
  parameter int unsigned            MAX_RETRIES  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                ack_lockout,
  input  logic [1:0]          sup_state,
  input  logic                sup_fault,
  input  logic signed [W-1:0] v_in,
  input  logic signed [W-1:0] i_in,
  output logic                start,
  output logic                clear_fault,
  output logic                lockout,
  output logic                timeout_err,
  output logic [7:0]          retry_cnt,
  output logic [2:0]          seq_state,
  output logic [W-1:0]        last_fault_v,
  output logic [W-1:0]        last_fault_i,
  output logic [15:0]         fault_count
);

  localparam int CW = $clog2(COOLDOWN_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);

  localparam logic [1:0] SUP_INIT  = 2'd0;
  localparam logic [1:0] SUP_RUN   = 2'd1;
  localparam logic [1:0] SUP_FAULT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RUN  = 3'd3,
    S_COOL = 3'd4,
    S_CLR  = 3'd5,
    S_LOCK = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cool_q, cool_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [SW-1:0]  stab_q, stab_d;
  logic [7:0]     retry_q, retry_d;
  logic           terr_q, terr_d;
  logic           start_q, clr_q, lock_q;
  logic           flt;

  // Next-state, counter and fault-path decisions
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    tmr_d   = tmr_q;
    stab_d  = stab_q;
    retry_d = retry_q;
    terr_d  = terr_q;
    flt     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sup_state == SUP_FAULT || sup_fault) begin
          state_d = S_COOL;
          cool_d  = CW'(COOLDOWN_CYC - 1);
        end else if (enable && sup_state == SUP_INIT) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        tmr_d   = TW'(TIMEOUT_CYC);
      end
      S_WAIT: begin
        if (sup_state == SUP_RUN) begin
          state_d = S_RUN;
          stab_d  = '0;
        end else if (sup_state == SUP_FAULT) begin
          flt = 1'b1;
        end else if (tmr_q <= TW'(1)) begin
          state_d = S_LOCK;
          terr_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_RUN: begin
        if (sup_fault || sup_state != SUP_RUN) begin
          flt = 1'b1;
        end else if (stab_q != SW'(STABLE_CYC)) begin
          stab_d = stab_q + SW'(1);
          if (stab_d == SW'(STABLE_CYC)) retry_d = 8'd0;
        end
      end
      S_COOL: begin
        if (cool_q != '0) begin
          cool_d = cool_q - CW'(1);
        end else if (v_in < V_SAFE && i_in < I_SAFE && enable) begin
          state_d = S_CLR;
          tmr_d   = TW'(TIMEOUT_CYC);
        end
      end
      S_CLR: begin
        if (sup_state == SUP_INIT) begin
          state_d = S_REQ;
        end else if (tmr_q <= TW'(1)) begin
          state_d = S_LOCK;
          terr_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_LOCK: begin
        if (ack_lockout) begin
          retry_d = 8'd0;
          terr_d  = 1'b0;
          if (sup_state == SUP_FAULT) begin
            state_d = S_COOL;
            cool_d  = CW'(COOLDOWN_CYC - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flt) begin
      retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
      if (retry_d > 8'(MAX_RETRIES)) begin
        state_d = S_LOCK;
      end else begin
        state_d = S_COOL;
        cool_d  = CW'(COOLDOWN_CYC - 1);
      end
    end
  end

  // State, counters and registered command outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cool_q  <= '0;
      tmr_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      terr_q  <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      tmr_q   <= tmr_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      terr_q  <= terr_d;
      start_q <= (state_d == S_REQ);
      clr_q   <= (state_d == S_CLR);
      lock_q  <= (state_d == S_LOCK);
    end
  end

  assign start       = start_q;
  assign clear_fault = clr_q;
  assign lockout     = lock_q;
  assign timeout_err = terr_q;
  assign retry_cnt   = retry_q;
  assign seq_state   = state_q;

`ifdef VI_SEQ_LOG_EN
  logic [W-1:0] lv_q, li_q;
  logic [15:0]  fc_q;

  // Capture samples on every fault-path entry; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      lv_q <= '0;
      li_q <= '0;
      fc_q <= '0;
    end else if (flt) begin
      lv_q <= v_in;
      li_q <= i_in;
      if (fc_q != 16'hFFFF) fc_q <= fc_q + 16'd1;
    end
  end

  assign last_fault_v = lv_q;
  assign last_fault_i = li_q;
  assign fault_count  = fc_q;
`else
  assign last_fault_v = '0;
  assign last_fault_i = '0;
  assign fault_count  = '0;
`endif

endmodule

// File: doc/vi_fault_recovery_seq.md
Name: vi_fault_recovery_seq

Overview:
- Host-side command sequencer on the other end of the V–I safety supervisor's start/clear_fault/state/fault interface.
- Drives start and clear_fault into the supervisor and reads back its 2-bit state and fault flag.
- Auto-restarts after a fault once a cooldown has expired and V/I have fallen below re-arm thresholds (hysteresis).
- Enters a latched lockout after too many consecutive faults or a handshake timeout.

Parameters:
- W, 16, sample width (signed Q1.15)
- V_SAFE, 16'sh4000, re-arm threshold for v_in; must satisfy V_SAFE <= supervisor V_MAX
- I_SAFE, 16'sh4000, re-arm threshold for i_in
- COOLDOWN_CYC, 1000, minimum cycles between fault detection and clear request (>=1)
- TIMEOUT_CYC, 64, maximum wait for the supervisor state to change after a command (>=2)
- STABLE_CYC, 4096, consecutive RUN cycles that reset retry_cnt to 0
- MAX_RETRIES, 3, faults tolerated before lockout (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  host permission to start/restart (level)
- ack_lockout  in  1  host acknowledge; releases LOCKOUT
- sup_state  in  2  supervisor state: 0=INIT, 1=RUN, 2=FAULT, 3=illegal
- sup_fault  in  1  supervisor fault flag
- v_in  in  W  signed V[n] (same sample the supervisor sees)
- i_in  in  W  signed I[n]
- start  out  1  one-cycle start request to the supervisor
- clear_fault  out  1  clear request to the supervisor (level, held)
- lockout  out  1  latched lockout indicator
- timeout_err  out  1  sticky: lockout was caused by a timeout
- retry_cnt  out  8  consecutive fault count
- seq_state  out  3  current sequencer state (encoding below)
- last_fault_v  out  W  optional capture (see Optional Feature)
- last_fault_i  out  W  optional capture
- fault_count  out  16  optional capture

Behaviour:
- All outputs registered. Reset (rst=1 at a clk edge): seq_state=IDLE, all outputs 0, all counters 0. Reset in any state aborts the operation immediately; clear_fault and start drop on the next edge.
- State encodings: IDLE=0, REQ_START=1, WAIT_RUN=2, RUNNING=3, COOLDOWN=4, CLEAR=5, LOCKOUT=6. Encoding 7 goes to IDLE on the next edge.
- IDLE: if sup_state==FAULT or sup_fault, go to COOLDOWN (load the counter; retry_cnt unchanged). Else, if enable and sup_state==INIT, go to REQ_START.
- REQ_START: start=1 for exactly this one cycle. Go to WAIT_RUN and load the timeout counter with TIMEOUT_CYC.
- WAIT_RUN:
  - sup_state==RUN: go to RUNNING and clear the stable counter.
  - sup_state==FAULT: take the fault path (below).
  - Timeout counter reaches 0: go to LOCKOUT and set timeout_err.
- RUNNING:
  - The stable counter increments each cycle. On reaching STABLE_CYC, retry_cnt=0 and the counter saturates.
  - sup_fault or sup_state!=RUN: take the fault path.
  - enable has no effect in this state (the supervisor has no stop command).
- Fault path:
  - retry_cnt increments, saturating at 255.
  - If the new retry_cnt > MAX_RETRIES, go to LOCKOUT.
  - Otherwise go to COOLDOWN and load COOLDOWN_CYC-1.
- COOLDOWN: count down to 0 and hold there. Exit to CLEAR only when the count is 0 AND v_in < V_SAFE AND i_in < I_SAFE (signed, strict) AND enable. Otherwise stay.
- CLEAR:
  - clear_fault=1 while in this state; timeout counter loaded with TIMEOUT_CYC on entry.
  - sup_state==INIT: clear_fault drops on the next edge; go to REQ_START.
  - Timeout: go to LOCKOUT and set timeout_err.
- LOCKOUT:
  - lockout=1; start and clear_fault are 0.
  - On ack_lockout: clear retry_cnt, timeout_err and lockout. Go to COOLDOWN if sup_state==FAULT, else IDLE.
- Simultaneous events:
  - rst has priority over everything.
  - In WAIT_RUN, sup_state==FAULT has priority over timeout expiry.
  - In RUNNING, a fault in the same cycle the stable counter reaches STABLE_CYC counts as a fault: retry_cnt is not cleared.
- Invariant: start and clear_fault are never both 1.

Optional Feature:
- Macro: VI_SEQ_LOG_EN.
- Defined:
  - On each fault-path entry, last_fault_v and last_fault_i latch that cycle's v_in and i_in.
  - fault_count increments, saturating at 16'hFFFF.
  - These registers are cleared only by rst, not by ack_lockout.
- Undefined: the three ports remain, tied to 0, and no capture registers are instantiated.

Test Plan:
- Clean start: rst, then enable=1 with sup_state=0 -> start pulses for 1 cycle in REQ_START. Model sup_state=1 one cycle later -> seq_state=3 and retry_cnt=0.
- Single fault recovery (COOLDOWN_CYC=10): in RUNNING, sup_state=2 with v_in=16'sh7000.
  - retry_cnt=1, seq_state=4.
  - After 10 cycles with v_in still high, stays in COOLDOWN.
  - Drop v_in to 16'sh1000 -> CLEAR with clear_fault=1 until sup_state=0 -> start pulse.
- Lockout on retries (MAX_RETRIES=3): 4 faults, each within 100 cycles of the restart (fewer than STABLE_CYC) -> after the 4th, lockout=1, retry_cnt=4, no start/clear. ack_lockout with sup_state=2 -> lockout=0, retry_cnt=0, seq_state=4.
- Stable reset (STABLE_CYC=16): fault, recover, run 16 cycles -> retry_cnt returns to 0. A fault on exactly the 16th cycle -> retry_cnt increments instead.
- Timeout: in WAIT_RUN, hold sup_state=0 for TIMEOUT_CYC=8 cycles -> LOCKOUT with timeout_err=1. Repeat with sup_state=2 arriving on the expiry cycle -> fault path taken, timeout_err=0.
- Reset mid-CLEAR, plus log (VI_SEQ_LOG_EN defined):
  - Assert rst while clear_fault=1 -> clear_fault=0 and seq_state=0 next cycle.
  - A fault with v_in=16'sh6000, i_in=16'sh0100 -> last_fault_v=16'sh6000, last_fault_i=16'sh0100, fault_count=1.
